// File: rtl/timing_stim_sequencer_if.sv
// Handshake bundle between a stimulus source and the timing sequencer.
// The master side drives launch/abort/config; the slave side (sequencer)
// drives the start level, the strobes and the status outputs.
interface timing_stim_sequencer_if #(
    parameter int DW = 4,
    parameter int CW = 8
);
    logic          go;
    logic          abort;
    logic [DW-1:0] cfg_delay1;
    logic [DW-1:0] cfg_delay2;
    logic          start;
    logic          trigger;
    logic          enable;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] seq_count;

    modport master (
        output go, abort, cfg_delay1, cfg_delay2,
        input  start, trigger, enable, busy, done, err, seq_count
    );

    modport slave (
        input  go, abort, cfg_delay1, cfg_delay2,
        output start, trigger, enable, busy, done, err, seq_count
    );
endinterface

// File: rtl/timing_stim_sequencer.sv
// Stimulus sequencer: on a launch request emits a start level, then a
// trigger strobe after delay1 idle cycles, an enable strobe after delay2
// more idle cycles, and finally a done strobe. Delays are captured at
// launch. Every output is a flop fed from the next-state logic, so there
// is no combinational path from inputs to outputs.
module timing_stim_sequencer #(
    parameter int DW = 4,
    parameter int CW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    timing_stim_sequencer_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT1 = 3'd1;
    localparam logic [2:0] S_TRIG  = 3'd2;
    localparam logic [2:0] S_WAIT2 = 3'd3;
    localparam logic [2:0] S_ENA   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] d1_q, d1_d;
    logic [DW-1:0] d2_q, d2_d;
    logic          err_d;

    logic          start_q, trigger_q, enable_q, busy_q, done_q, err_q;
    logic [CW-1:0] seq_count_q;

    // Next-state logic; abort overrides every normal transition outside IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    d1_d    = bus.cfg_delay1;
                    d2_d    = bus.cfg_delay2;
                    cnt_d   = '0;
                    state_d = (bus.cfg_delay1 != '0) ? S_WAIT1 : S_TRIG;
                end
            end
            S_WAIT1: begin
                if (cnt_q == d1_q - DW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_TRIG;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            S_TRIG: begin
                state_d = (d2_q != '0) ? S_WAIT2 : S_ENA;
            end
            S_WAIT2: begin
                if (cnt_q == d2_q - DW'(1)) begin
                    cnt_d   = '0;
                    state_d = S_ENA;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            S_ENA:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
        end
    end

    // State, latched delays and counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
        end
    end

    // Registered outputs decoded from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            trigger_q   <= 1'b0;
            enable_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            seq_count_q <= '0;
        end else begin
            start_q   <= (state_d == S_WAIT1) || (state_d == S_TRIG) ||
                         (state_d == S_WAIT2) || (state_d == S_ENA);
            busy_q    <= (state_d == S_WAIT1) || (state_d == S_TRIG) ||
                         (state_d == S_WAIT2) || (state_d == S_ENA);
            trigger_q <= (state_d == S_TRIG);
            enable_q  <= (state_d == S_ENA);
            done_q    <= (state_d == S_DONE);
            err_q     <= err_d;
            // Count on DONE entry; a later abort in DONE does not undo it.
            if (state_d == S_DONE && state_q != S_DONE)
                seq_count_q <= seq_count_q + CW'(1);
        end
    end

    assign bus.start     = start_q;
    assign bus.busy      = busy_q;
    assign bus.trigger   = trigger_q;
    assign bus.enable    = enable_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.seq_count = seq_count_q;
endmodule

// File: doc/timing_stim_sequencer.md
Name: timing_stim_sequencer

Overview:
- Synthesizable stimulus sequencer that sits directly upstream of the wait/fork/event consumer blocks.
- Produces their `start` level plus delayed `trigger` and `enable` strobes, with cycle-exact, programmable spacing.
- A `go` request launches one sequence. Delays are latched at launch, so consumers see a deterministic handshake order: `start`, then `trigger`, then `enable`, then `done`.

Parameters:
- `DW`, default 4: width of each delay field; maximum delay is 2^DW-1 cycles.
- `CW`, default 8: width of the completed-sequence counter.

Ports:
- `clk`  input  1  clock, all state on posedge.
- `rst`  input  1  asynchronous active-low reset.
- `go`  input  1  launch request, sampled at posedge.
- `abort`  input  1  synchronous cancel of the running sequence.
- `cfg_delay1`  input  DW  idle cycles between `start` and `trigger`.
- `cfg_delay2`  input  DW  idle cycles between `trigger` and `enable`.
- `start`  output  1  level, high for the whole sequence.
- `trigger`  output  1  one-cycle strobe.
- `enable`  output  1  one-cycle strobe.
- `busy`  output  1  sequence in progress.
- `done`  output  1  one-cycle completion strobe.
- `err`  output  1  one-cycle abort-acknowledge strobe.
- `seq_count`  output  CW  count of completed sequences.

Behaviour:
- **Reset:** `rst` low asynchronously forces state IDLE and clears `start`, `trigger`, `enable`, `busy`, `done`, `err`, `seq_count`, counter and latched delays. This holds regardless of state (reset mid-sequence included); there is no cleanup pulse. Reset release is synchronous to the next posedge.
- **States:** IDLE, WAIT1, TRIG, WAIT2, ENA, DONE. All outputs are registered; no combinational path from inputs to outputs.
- **IDLE:**
  - `go`=1 at edge E0: latch d1=`cfg_delay1`, d2=`cfg_delay2`; set `start`=1, `busy`=1; clear counter.
  - Go to WAIT1 if d1>0, else TRIG.
  - `go`=0: stay.
- **WAIT1:** counter increments each edge. When counter reaches d1-1, clear the counter and go to TRIG. Net effect: WAIT1 lasts exactly d1 cycles.
- **TRIG:** `trigger`=1 for exactly this cycle. Next state is WAIT2 if d2>0, else ENA.
- **WAIT2:** same counting as WAIT1, lasting exactly d2 cycles, then ENA.
- **ENA:** `enable`=1 for exactly this cycle; next state DONE.
- **DONE:**
  - `done`=1 for one cycle, with `start`=0 and `busy`=0 in the same cycle.
  - `seq_count` increments at this entry and wraps (2^CW-1 -> 0).
  - Next state IDLE.
- **Timing relative to E0:**
  - `trigger` is high in the cycle after edge E0+d1.
  - `enable` is high in the cycle after edge E0+d1+d2+1.
  - `done` is high in the cycle after edge E0+d1+d2+2.
  - Total busy time is d1+d2+2 cycles.
- **`go` rules:**
  - `go` while busy, or in DONE, is ignored; it is not queued.
  - `go` held high relaunches from IDLE, so there is exactly one idle cycle between sequences.
- **Config changes:** `cfg_*` changes after E0 have no effect on the running sequence.
- **Abort:**
  - `abort`=1 at an edge while in WAIT1/TRIG/WAIT2/ENA/DONE goes to IDLE.
  - `start`, `busy`, `trigger`, `enable` and `done` go to 0; `err`=1 for one cycle.
  - `seq_count` is unchanged, including an abort taken in the DONE cycle: the DONE-entry increment stands and is not reversed.
  - `abort` has priority over every normal transition.
  - `abort` in IDLE is ignored (no `err`), even if `go` is also high; in that case `go` launches normally.
- **Strobe exclusivity:** `trigger`, `enable`, `done` and `err` are never high in the same cycle.

Test Plan:
- **Reset:** reset asserted -> all outputs 0; release, with `go`=0 for 10 cycles -> outputs remain 0.
- **Normal sequence:** d1=3, d2=2, `go` pulse at edge 0 -> `start`/`busy` high cycles 1-7; `trigger` in cycle 4, `enable` in cycle 7, `done` in cycle 8; `seq_count`=1.
- **Zero delays:** d1=0, d2=0 -> `trigger` in cycle 1, `enable` in cycle 2, `done` in cycle 3. A `cfg` change to 15/15 at cycle 1 does not alter this timing.
- **Abort mid-WAIT2:** d1=2, d2=5, `abort` at edge 5 -> `err` high in cycle 6 only; `enable` never asserts; `seq_count` unchanged; a new `go` starts a clean sequence.
- **Held go and wrap:** `go` held high, d1=0, d2=0 -> `done` every 4 cycles. With `CW`=2, the 4th `done` wraps `seq_count` to 0. A `go` pulse while busy is ignored.
- **Async reset mid-sequence:** reset asserted in WAIT1 -> outputs clear immediately, without waiting for a clock edge; no `done`/`err` after release.
